logic_pipe: RTL and testbench
=============================

LOGIC_PIPE -- requirements
Module: logic_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal range 1..64).
REQ-002 SHALL have parameter ZERO_FLAG, default 1, meaning that the zero flag is computed (1) or tied low (0).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand beat offered.
REQ-006 SHALL have port in_ready, output, 1 bit: beat accepted when in_valid && in_ready.
REQ-007 SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 SHALL have port op, input, 2 bits: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-009 SHALL have port out_valid, output, 1 bit: result beat present.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts when out_valid && out_ready.
REQ-011 SHALL have port out, output, WIDTH bits: the result.
REQ-012 SHALL have port zero, output, 1 bit: out == 0 (when ZERO_FLAG=1).
REQ-013 SHALL have port parity, output, 1 bit: XOR-reduction of out (present only under LOGIC_PIPE_PARITY_EN).

Function
REQ-014 SHALL be a two-stage valid/ready pipeline: S1 registers the bitwise result of a, b and op; S2 registers the result plus its flags.
REQ-015 SHALL have a latency of 2 cycles: a beat accepted at edge N appears at out with out_valid=1 after edge N+2 when there is no stall.
REQ-016 SHALL sustain a throughput of 1 beat per cycle while out_ready=1.
REQ-017 SHALL compute the S2 ready term as !s2_valid || out_ready, and the S1 ready term as !s1_valid || s2_ready; in_ready SHALL equal the S1 ready term (combinational, no bubble).
REQ-018 SHALL hold out, zero, parity and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL keep every stage holding its data unchanged when stalled; no beat SHALL be dropped or duplicated.
REQ-020 SHALL clear S1 valid on an S1-to-S2 transfer that has no simultaneous new input.
REQ-021 SHALL, when S1 transfers to S2 in the same cycle a new input is accepted, load S1 with the new beat and S2 with the old S1 beat.
REQ-022 SHALL sample op per beat; changing op between beats SHALL NOT affect beats already in flight.
REQ-023 SHALL produce NOR as the bitwise inverse of OR over exactly WIDTH bits; no bits above WIDTH-1 exist.
REQ-024 SHALL compute zero from the S1 result registered into S2, not from a, b or op directly.

Reset
REQ-025 SHALL, while rst=1 at a rising edge, clear s1_valid and s2_valid, and set out, zero and parity to 0, out_valid to 0 and in_ready to 1 in the following cycle.
REQ-026 SHALL discard all in-flight beats on rst asserted mid-stream; the first beat after reset deasserts SHALL take the full 2-cycle latency.
REQ-027 SHALL NOT accept any input beat in a cycle where rst=1.

Configuration
REQ-028 SHALL, with macro LOGIC_PIPE_PARITY_EN defined, provide a parity port registered in S2 alongside zero.
REQ-029 SHALL, with LOGIC_PIPE_PARITY_EN undefined, have no parity port and no parity logic; all other behaviour SHALL be identical.

Structure
REQ-030 SHALL take the op encodings (OP_AND, OP_OR, OP_XOR, OP_NOR) and the 2-bit op typedef from shared package logic_pipe_pkg.
REQ-031 SHALL implement each stage as an instance of sub-module logic_pipe_stage, a generic WIDTH-parametrised valid/ready register stage.

Verification
REQ-032 SHALL verify back-to-back operation: WIDTH=32, out_ready=1, beats (FFFFFFFF,00000000,AND), (FFFFFFFF,00000000,OR), (0F0F0F0F,FF00FF00,XOR), (00000000,00000000,NOR) -> out 00000000 (zero=1), FFFFFFFF, F00FF00F, FFFFFFFF on consecutive cycles starting 2 cycles after the first accept.
REQ-033 SHALL verify a walking-one pattern: a=b=1<<i for i=0..31 with op=AND -> out=1<<i and zero=0 for each i; with op=XOR -> out=0 and zero=1.
REQ-034 SHALL verify backpressure: hold out_ready=0 for 5 cycles while streaming 3 beats -> in_ready falls after 2 beats are held, out stays at the first result, and all 3 results emerge in order with no loss once out_ready=1.
REQ-035 SHALL verify reset mid-stream: assert rst with both stages valid -> out_valid=0 and in_ready=1 next cycle, and a beat (80031F4F,FFDF1F40,AND) sent afterwards gives out=80031F40 two cycles later.
REQ-036 SHALL verify parity under LOGIC_PIPE_PARITY_EN: (00000007,FFFFFFFF,AND) -> parity=1, and (00000003,FFFFFFFF,AND) -> parity=0.
REQ-037 SHALL verify the WIDTH=8 instance: (A5,5A,NOR) -> out=00 with zero=1.

Source files
------------

// File: rtl/logic_pipe_pkg.sv
// Shared definitions for the logic_pipe block: the 2-bit operation encoding
// used on the op port and by the first pipeline stage.
package logic_pipe_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

endpackage

// File: rtl/logic_pipe_stage.sv
// Generic single-entry valid/ready register stage. Ready is asserted whenever
// the stage is empty or its content leaves this cycle, so stages chain with no bubble.
module logic_pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Data only changes on an accepted beat, so a stalled or drained stage keeps its value.
    always_comb begin
        in_ready = !valid_q || out_ready;
        valid_d  = valid_q;
        data_d   = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/logic_pipe.sv
// Two-stage valid/ready bitwise logic unit: S1 holds the AND/OR/XOR/NOR result,
// S2 holds the result plus flags. Define LOGIC_PIPE_PARITY_EN to add the parity output.
module logic_pipe
    import logic_pipe_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ZERO_FLAG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero
`ifdef LOGIC_PIPE_PARITY_EN
    ,
    output logic             parity
`endif
);

`ifdef LOGIC_PIPE_PARITY_EN
    localparam int S2W = WIDTH + 2;
`else
    localparam int S2W = WIDTH + 1;
`endif

    logic [WIDTH-1:0] opResult;
    logic [WIDTH-1:0] s1Data;
    logic             s1Valid;
    logic             s2Ready;
    logic             s1Zero;
    logic [S2W-1:0]   s2In;
    logic [S2W-1:0]   s2Data;

    always_comb begin
        opResult = '0;
        case (op)
            OP_AND: opResult = a & b;
            OP_OR:  opResult = a | b;
            OP_XOR: opResult = a ^ b;
            OP_NOR: opResult = ~(a | b);
        endcase
    end

    logic_pipe_stage #(.WIDTH(WIDTH)) uStage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (opResult),
        .out_valid (s1Valid),
        .out_ready (s2Ready),
        .out_data  (s1Data)
    );

    // Flags are derived from the registered S1 result, never from the raw operands.
    assign s1Zero = (ZERO_FLAG != 0) ? (s1Data == '0) : 1'b0;

`ifdef LOGIC_PIPE_PARITY_EN
    assign s2In = {^s1Data, s1Zero, s1Data};
`else
    assign s2In = {s1Zero, s1Data};
`endif

    logic_pipe_stage #(.WIDTH(S2W)) uStage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1Valid),
        .in_ready  (s2Ready),
        .in_data   (s2In),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2Data)
    );

    assign out  = s2Data[WIDTH-1:0];
    assign zero = s2Data[WIDTH];
`ifdef LOGIC_PIPE_PARITY_EN
    assign parity = s2Data[WIDTH+1];
`endif

endmodule

// File: tb/tb_logic_pipe.sv
// Scoreboard bench for logic_pipe: a truth-table model predicts each accepted
// beat, a monitor compares every presented output against the queue head.
module tb_logic_pipe;
    import logic_pipe_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        zf;
        logic        pf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] aSig = '0;
    logic [31:0] bSig = '0;
    op_e         opSig = OP_AND;
    logic        outValid;
    logic        outReady;
    logic [31:0] outSig;
    logic        zeroSig;
    logic        parSig;

    logic        inValid8 = 1'b0;
    logic        inReady8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    op_e         op8 = OP_AND;
    logic        outValid8;
    logic [7:0]  out8;
    logic        zero8;

    logic        randReady = 1'b0;
    logic        randBit = 1'b1;
    logic        fixedReady = 1'b1;
    assign outReady = randReady ? randBit : fixedReady;

    int testCount = 0;
    int failCount = 0;
    int cycleCount = 0;
    exp_t sb[$];

    bit latArmed = 0;
    bit latAccepted = 0;
    int acceptCycle = 0;
    bit tputArmed = 0;
    int lastPopCycle = -1;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    always @(posedge clk) begin
        #1;
        randBit = ($urandom_range(0, 3) != 0);
    end

    logic_pipe #(.WIDTH(32), .ZERO_FLAG(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (aSig),
        .b         (bSig),
        .op        (opSig),
        .out_valid (outValid),
        .out_ready (outReady),
        .out       (outSig),
        .zero      (zeroSig)
`ifdef LOGIC_PIPE_PARITY_EN
        ,
        .parity    (parSig)
`endif
    );

`ifdef LOGIC_PIPE_PARITY_EN
    logic par8;
`else
    assign parSig = 1'b0;
`endif

    logic_pipe #(.WIDTH(8), .ZERO_FLAG(1)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid8),
        .in_ready  (inReady8),
        .a         (a8),
        .b         (b8),
        .op        (op8),
        .out_valid (outValid8),
        .out_ready (1'b1),
        .out       (out8),
        .zero      (zero8)
`ifdef LOGIC_PIPE_PARITY_EN
        ,
        .parity    (par8)
`endif
    );

    // Reference model: each result bit is looked up in the operation's truth table.
    function automatic exp_t refModel(input logic [31:0] x, input logic [31:0] y, input int o);
        exp_t e;
        logic [3:0] tt;
        int ones;
        case (o)
            0: tt = 4'b1000;
            1: tt = 4'b1110;
            2: tt = 4'b0110;
            default: tt = 4'b0001;
        endcase
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            e.res[i] = tt[{x[i], y[i]}];
            ones += int'(e.res[i]);
        end
        e.zf = (ones == 0);
`ifdef LOGIC_PIPE_PARITY_EN
        e.pf = (ones % 2) == 1;
`else
        e.pf = 1'b0;
`endif
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycleCount);
        end
    endtask

    // Scoreboard push: every handshake the DUT will take at the coming edge.
    always @(negedge clk) begin
        if (!rst && inValid && inReady) begin
            sb.push_back(refModel(aSig, bSig, int'(opSig)));
            if (latArmed && !latAccepted) begin
                latAccepted = 1;
                acceptCycle = cycleCount;
            end
        end
    end

    // Monitor: whatever sits on the output, stalled or not, must be the queue head.
    always @(negedge clk) begin
        if (!rst && outValid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_out_valid", 64'(outValid), 64'd0);
            end else begin
                checkOutput("out", 64'(outSig), 64'(sb[0].res));
                checkOutput("zero", 64'(zeroSig), 64'(sb[0].zf));
`ifdef LOGIC_PIPE_PARITY_EN
                checkOutput("parity", 64'(parSig), 64'(sb[0].pf));
`endif
                if (latAccepted) begin
                    checkOutput("latency", 64'(cycleCount - acceptCycle), 64'd2);
                    latArmed = 0;
                    latAccepted = 0;
                end
                if (outReady) begin
                    if (tputArmed && lastPopCycle >= 0)
                        checkOutput("throughput", 64'(cycleCount - lastPopCycle), 64'd1);
                    lastPopCycle = cycleCount;
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input int o);
        bit got;
        @(posedge clk);
        #1;
        inValid = 1'b1;
        aSig = x;
        bSig = y;
        opSig = op_e'(o);
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (inReady) got = 1;
        end
        if (!got) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idleIn();
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic checkResetState(input string tag);
        @(negedge clk);
        checkOutput({tag, "_out_valid"}, 64'(outValid), 64'd0);
        checkOutput({tag, "_in_ready"}, 64'(inReady), 64'd1);
        checkOutput({tag, "_out"}, 64'(outSig), 64'd0);
        checkOutput({tag, "_zero"}, 64'(zeroSig), 64'd0);
    endtask

    initial begin
        bit got;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetState("reset");

        // Back-to-back directed beats with latency and throughput tracking.
        latArmed = 1;
        tputArmed = 1;
        lastPopCycle = -1;
        applyStimulus(32'hFFFFFFFF, 32'h00000000, 0);
        applyStimulus(32'hFFFFFFFF, 32'h00000000, 1);
        applyStimulus(32'h0F0F0F0F, 32'hFF00FF00, 2);
        applyStimulus(32'h00000000, 32'h00000000, 3);
        idleIn();
        drain();
        tputArmed = 0;

        for (int i = 0; i < 32; i++) applyStimulus(32'd1 << i, 32'd1 << i, 0);
        for (int i = 0; i < 32; i++) applyStimulus(32'd1 << i, 32'd1 << i, 2);
        idleIn();
        drain();

        // Backpressure: two beats fill the pipe, the third waits at the input.
        fixedReady = 1'b0;
        applyStimulus(32'h12345678, 32'h0000FFFF, 0);
        applyStimulus(32'h12345678, 32'h0000FFFF, 1);
        @(posedge clk);
        #1;
        aSig = 32'hA5A5A5A5;
        bSig = 32'h5A5A5A5A;
        opSig = OP_XOR;
        repeat (5) begin
            @(negedge clk);
            checkOutput("in_ready_stalled", 64'(inReady), 64'd0);
            checkOutput("out_valid_stalled", 64'(outValid), 64'd1);
        end
        @(posedge clk);
        #1;
        fixedReady = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (inReady) got = 1;
        end
        if (!got) checkOutput("accept_timeout", 64'd0, 64'd1);
        idleIn();
        drain();

        // Reset with both stages holding beats.
        fixedReady = 1'b0;
        applyStimulus(32'hDEADBEEF, 32'hFFFF0000, 0);
        applyStimulus(32'hCAFEF00D, 32'h0000FFFF, 1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        fixedReady = 1'b1;
        checkResetState("midreset");
        latArmed = 1;
        applyStimulus(32'h80031F4F, 32'hFFDF1F40, 0);
        idleIn();
        drain();

        applyStimulus(32'h00000007, 32'hFFFFFFFF, 0);
        applyStimulus(32'h00000003, 32'hFFFFFFFF, 0);
        idleIn();
        drain();

        // Random traffic with random gaps and random downstream stalls.
        randReady = 1'b1;
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom, $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 4) == 0) idleIn();
        end
        idleIn();
        randReady = 1'b0;
        drain();

        // Narrow instance.
        @(posedge clk);
        #1;
        inValid8 = 1'b1;
        a8 = 8'hA5;
        b8 = 8'h5A;
        op8 = OP_NOR;
        @(negedge clk);
        checkOutput("w8_in_ready", 64'(inReady8), 64'd1);
        @(posedge clk);
        #1;
        inValid8 = 1'b0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (outValid8) got = 1;
        end
        checkOutput("w8_out_valid", 64'(got), 64'd1);
        checkOutput("w8_out", 64'(out8), 64'h00);
        checkOutput("w8_zero", 64'(zero8), 64'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
